// File: rtl/processor.sv
// Sequencer that fills 18 result registers from a constant operand ROM, with registered readback on q.
// Optional feature: define PROCESSOR_GPIO_STATUS_EN to drive registered run status on gpio2.
module processor (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  switches,
    input  logic [23:0] parallelAddress,
    input  logic [35:0] gpio1,
    output logic [35:0] gpio2,
    output logic [15:0] q
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      r_state, w_state_next;
    logic [4:0]  r_idx, w_idx_next;
    logic        w_we;
    logic [1:0]  w_group;
    logic [2:0]  w_lane;
    logic [15:0] w_result;
    logic [15:0] w_res [18];
    logic [7:0]  w_a;
    logic [15:0] w_rd_data;
    logic [15:0] r_q;

    function automatic logic [15:0] rom_word(input logic [7:0] a);
        case (a)
            8'd4:   return 16'd5;
            8'd5:   return 16'd7;
            8'd6:   return 16'd13;
            8'd7:   return 16'd19;
            8'd8:   return 16'd23;
            8'd9:   return 16'd24;
            8'd10:  return 16'd2;
            8'd11:  return 16'd4;
            8'd12:  return 16'd6;
            8'd13:  return 16'd7;
            8'd14:  return 16'd9;
            8'd15:  return 16'd33;
            8'd100: return 16'd1000;
            8'd101: return 16'd999;
            8'd102: return 16'd999;
            8'd103: return 16'd998;
            8'd104: return 16'd997;
            8'd105: return 16'd996;
            8'd200: return 16'd0;
            8'd201: return 16'd17;
            8'd202: return 16'd34;
            8'd203: return 16'd52;
            8'd204: return 16'd69;
            8'd205: return 16'd87;
            default: return 16'd0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_we         = 1'b0;
        case (r_state)
            IDLE: begin
                if (switches[0]) begin
                    w_state_next = RUN;
                    w_idx_next   = '0;
                end
            end
            RUN: begin
                if (switches[0]) begin
                    w_we       = 1'b1;
                    w_idx_next = r_idx + 5'd1;
                    if (r_idx == 5'd17)
                        w_state_next = DONE;
                end
            end
            DONE:    w_state_next = DONE;
            default: w_state_next = IDLE;
        endcase
    end

    // idx selects one of three six-entry groups; lane is the position inside the group
    always_comb begin
        w_group = 2'd0;
        w_lane  = r_idx[2:0];
        if (r_idx >= 5'd12) begin
            w_group = 2'd2;
            w_lane  = 3'(r_idx - 5'd12);
        end else if (r_idx >= 5'd6) begin
            w_group = 2'd1;
            w_lane  = 3'(r_idx - 5'd6);
        end
    end

    always_comb begin
        case (w_group)
            2'd0:    w_result = rom_word(8'd4 + {5'd0, w_lane}) + rom_word(8'd10 + {5'd0, w_lane});
            2'd1:    w_result = rom_word(8'd100 + {5'd0, w_lane}) << 1;
            default: w_result = rom_word(8'd200 + {5'd0, w_lane}) << 1;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 18; gi++) begin : g_res
            logic [15:0] r_word;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    r_word <= '0;
                else if (w_we && (r_idx == 5'(gi)))
                    r_word <= w_result;
            end
            assign w_res[gi] = r_word;
        end
    endgenerate

    assign w_a = parallelAddress[7:0];

    always_comb begin
        w_rd_data = '0;
        if (parallelAddress[23:8] == 16'd0) begin
            if (w_a >= 8'd30 && w_a <= 8'd35)
                w_rd_data = w_res[5'(w_a - 8'd30)];
            else if (w_a >= 8'd124 && w_a <= 8'd129)
                w_rd_data = w_res[5'(w_a - 8'd118)];
            else if (w_a >= 8'd224 && w_a <= 8'd229)
                w_rd_data = w_res[5'(w_a - 8'd212)];
            else
                w_rd_data = rom_word(w_a);
        end
    end

    // readback samples registers before this edge's sequencer write lands
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_q <= '0;
        else
            r_q <= switches[4] ? w_rd_data : 16'd0;
    end

    assign q = r_q;

`ifdef PROCESSOR_GPIO_STATUS_EN
    logic [35:0] r_gpio2;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_gpio2 <= '0;
        else
            r_gpio2 <= {r_state == DONE, r_state == RUN, 13'd0, r_idx, gpio1[15:0]};
    end
    assign gpio2 = r_gpio2;
    logic w_unused;
    assign w_unused = ^{switches[3:1], gpio1[35:16]};
`else
    assign gpio2 = '0;
    logic w_unused;
    assign w_unused = ^{switches[3:1], gpio1};
`endif

endmodule

// File: tb/tb_processor.sv
// Self-checking bench for processor: vector table, directed multi-cycle sequences and a randomized
// run compared against a spec-level model (written-result count plus the operand tables).
module tb_processor;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  switches;
    logic [23:0] parallelAddress;
    logic [35:0] gpio1;
    logic [35:0] gpio2;
    logic [15:0] q;

    int total = 0;
    int bad   = 0;

    int op_a   [6] = '{5, 7, 13, 19, 23, 24};
    int op_b   [6] = '{2, 4, 6, 7, 9, 33};
    int op_cos [6] = '{1000, 999, 999, 998, 997, 996};
    int op_sin [6] = '{0, 17, 34, 52, 69, 87};

    typedef struct {
        logic [23:0] addr;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[$];

    processor dut (
        .clk(clk),
        .rst(rst),
        .switches(switches),
        .parallelAddress(parallelAddress),
        .gpio1(gpio1),
        .gpio2(gpio2),
        .q(q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        switches = 5'b00000;
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
    endtask

    task automatic read_at(input string name, input logic [23:0] addr, input logic [15:0] exp);
        parallelAddress = addr;
        tick(1);
        check(name, {20'd0, q}, {20'd0, exp});
    endtask

    // nw = number of results the sequencer has written so far (written in order 0..17)
    function automatic logic [15:0] model_read(input logic [23:0] addr, input int nw);
        int a;
        if (addr[23:8] != 16'd0) return 16'd0;
        a = int'(addr[7:0]);
        if (a >= 4 && a <= 9)     return 16'(op_a[a - 4]);
        if (a >= 10 && a <= 15)   return 16'(op_b[a - 10]);
        if (a >= 100 && a <= 105) return 16'(op_cos[a - 100]);
        if (a >= 200 && a <= 205) return 16'(op_sin[a - 200]);
        if (a >= 30 && a <= 35)   return (nw > a - 30)       ? 16'(op_a[a - 30] + op_b[a - 30]) : 16'd0;
        if (a >= 124 && a <= 129) return (nw > 6 + a - 124)  ? 16'(op_cos[a - 124] * 2) : 16'd0;
        if (a >= 224 && a <= 229) return (nw > 12 + a - 224) ? 16'(op_sin[a - 224] * 2) : 16'd0;
        return 16'd0;
    endfunction

    task automatic run_random(input int n);
        bit          started = 0;
        int          nw = 0;
        logic        en, rb;
        logic [23:0] addr;
        logic [35:0] g1, exp_g2;
        logic [15:0] exp_q;
        for (int k = 0; k < n; k++) begin
            en = ($urandom_range(0, 3) != 0);
            rb = 1'($urandom_range(0, 1));
            g1 = {4'($urandom), 32'($urandom)};
            case ($urandom_range(0, 4))
                0: addr = {16'd0, 8'($urandom_range(0, 255))};
                1: addr = 24'(30 + $urandom_range(0, 5));
                2: addr = 24'(124 + $urandom_range(0, 5));
                3: addr = 24'(224 + $urandom_range(0, 5));
                default: addr = {16'($urandom_range(1, 65535)), 8'($urandom_range(0, 255))};
            endcase
            switches        = {rb, 3'($urandom), en};
            parallelAddress = addr;
            gpio1           = g1;
            exp_q = rb ? model_read(addr, nw) : 16'd0;
`ifdef PROCESSOR_GPIO_STATUS_EN
            exp_g2 = {nw == 18, started && nw < 18, 13'd0, 5'(nw), g1[15:0]};
`else
            exp_g2 = 36'd0;
`endif
            if (!started) started = en;
            else if (en && nw < 18) nw++;
            tick(1);
            check($sformatf("rand%0d q a=%0h", k, addr), {20'd0, q}, {20'd0, exp_q});
            check($sformatf("rand%0d gpio2", k), gpio2, exp_g2);
        end
    endtask

    initial begin
        rst = 1'b0;
        switches = 5'b00000;
        parallelAddress = 24'd0;
        gpio1 = 36'h0_0000_BEEF;
        #2;
        check("reset q", {20'd0, q}, 36'd0);
        check("reset gpio2", gpio2, 36'd0);
        tick(1);
        rst = 1'b1;

        // full run
        switches = 5'b00001;
        tick(200);
`ifdef PROCESSOR_GPIO_STATUS_EN
        check("gpio2 done flag", {35'd0, gpio2[35]}, 36'd1);
        check("gpio2 low word", {20'd0, gpio2[15:0]}, 36'hBEEF);
`else
        check("gpio2 idle zero", gpio2, 36'd0);
`endif

        for (int i = 0; i < 12; i++)
            vecs.push_back('{24'(4 + i), (i < 6) ? 16'(op_a[i]) : 16'(op_b[i - 6])});
        vecs.push_back('{24'd30, 16'd7});
        vecs.push_back('{24'd31, 16'd11});
        vecs.push_back('{24'd32, 16'd19});
        vecs.push_back('{24'd33, 16'd26});
        vecs.push_back('{24'd34, 16'd32});
        vecs.push_back('{24'd35, 16'd57});
        vecs.push_back('{24'd124, 16'd2000});
        vecs.push_back('{24'd125, 16'd1998});
        vecs.push_back('{24'd126, 16'd1998});
        vecs.push_back('{24'd127, 16'd1996});
        vecs.push_back('{24'd128, 16'd1994});
        vecs.push_back('{24'd129, 16'd1992});
        vecs.push_back('{24'd224, 16'd0});
        vecs.push_back('{24'd225, 16'd34});
        vecs.push_back('{24'd226, 16'd68});
        vecs.push_back('{24'd227, 16'd104});
        vecs.push_back('{24'd228, 16'd138});
        vecs.push_back('{24'd229, 16'd174});
        vecs.push_back('{24'd100, 16'd1000});
        vecs.push_back('{24'd205, 16'd87});
        vecs.push_back('{24'd16, 16'd0});
        vecs.push_back('{24'd130, 16'd0});
        vecs.push_back('{24'h000104, 16'd0});
        vecs.push_back('{24'h01001E, 16'd0});

        switches = 5'b10100;
        foreach (vecs[i])
            read_at($sformatf("table a=%0d", vecs[i].addr), vecs[i].addr, vecs[i].exp);

        switches = 5'b00100;
        read_at("readback off", 24'd30, 16'd0);

        // same-cycle read of the register being written returns the old value
        do_reset();
        parallelAddress = 24'd30;
        switches = 5'b10001;
        tick(1);
        check("sum0 before run", {20'd0, q}, 36'd0);
        tick(1);
        check("sum0 pre-write", {20'd0, q}, 36'd0);
        tick(1);
        check("sum0 post-write", {20'd0, q}, 36'd7);

        // pause partway through the SUM group, then resume
        do_reset();
        switches = 5'b00001;
        tick(6);
        switches = 5'b10000;
        tick(3);
        read_at("paused sum3", 24'd33, 16'd26);
        read_at("paused cos2_0", 24'd124, 16'd0);
        switches = 5'b10001;
        tick(30);
        switches = 5'b10000;
        read_at("resumed cos2_0", 24'd124, 16'd2000);

        // reset in the middle of a run
        do_reset();
        parallelAddress = 24'd30;
        switches = 5'b10001;
        tick(10);
        check("pre-reset sum0", {20'd0, q}, 36'd7);
        rst = 1'b0;
        #2;
        check("async reset q", {20'd0, q}, 36'd0);
        check("async reset gpio2", gpio2, 36'd0);
        switches = 5'b10000;
        tick(1);
        rst = 1'b1;
        read_at("sum0 after reset", 24'd30, 16'd0);
        switches = 5'b10001;
        tick(30);
        switches = 5'b10000;
        read_at("sum0 after rerun", 24'd30, 16'd7);
        read_at("high addr bits", 24'h000104, 16'd0);

        do_reset();
        run_random(80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
